// File: rtl/harmonic_sum_controller_pkg.sv
// Shared types and sizing for the harmonic-sum controller.
package harmonic_sum_controller_pkg;

    localparam int N_W     = 5;   // width of the term count n
    localparam int SUM_W   = 20;  // UQ4.16 sum width
    localparam int MAX_N   = 20;  // ROM depth, largest legal n
    localparam int TIMEOUT = 32;  // ACCUM cycles before the watchdog aborts

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FETCH,
        S_ACCUM,
        S_LAST,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_RANGE   = 2'd1,
        ERR_TIMEOUT = 2'd2
    } err_t;

endpackage

// File: rtl/harmonic_sum_controller_if.sv
// Job request / result handshake between a client and the controller.
interface harmonic_sum_controller_if #(
    parameter int N_W   = 5,
    parameter int SUM_W = 20
);
    logic             start;
    logic [N_W-1:0]   n_in;
    logic             ready;
    logic [SUM_W-1:0] result;
    logic [1:0]       err;
    logic             result_valid;
    logic             result_ready;

    // Client side: issues jobs and consumes results.
    modport master (
        output start, n_in, result_ready,
        input  ready, result, err, result_valid
    );

    // Controller side.
    modport slave (
        input  start, n_in, result_ready,
        output ready, result, err, result_valid
    );
endinterface

// File: rtl/harmonic_sum_controller_watchdog.sv
// Cycle counter that flags when it has been enabled TIMEOUT cycles in a row.
module harmonic_watchdog #(
    parameter int TIMEOUT = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic done
);
    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [WD_W-1:0] cnt;

    // Count enabled cycles; hold at the terminal value so the flag cannot wrap away.
    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (en && !done)
            cnt <= cnt + 1'b1;
    end

    // Terminal flag is high during the TIMEOUT-th enabled cycle.
    assign done = (cnt == WD_W'(TIMEOUT - 1));

endmodule

// File: rtl/harmonic_sum_controller.sv
// Sequencer for the harmonic-sum datapath: accepts a job, steps the datapath
// through load/fetch/accumulate, captures the sum and hands it back with an error code.
module harmonic_sum_controller
    import harmonic_sum_controller_pkg::*;
#(
    parameter int P_N_W     = N_W,
    parameter int P_SUM_W   = SUM_W,
    parameter int P_MAX_N   = MAX_N,
    parameter int P_TIMEOUT = TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    harmonic_sum_controller_if.slave job,
    output logic [P_N_W-1:0]   dp_n,
    output logic               dp_n_en,
    output logic               dp_count_en,
    output logic               dp_add_en,
    output logic               dp_rst,
    output logic               dp_n_rst,
    input  logic               dp_cmp,
    input  logic [P_SUM_W-1:0] dp_sum
);
    state_t state, state_nxt;
    logic   load_n, cap_sum, set_range, set_tmo;
    logic   wd_done;

    // Watchdog only runs while accumulating; any other state clears it.
    harmonic_watchdog #(.TIMEOUT(P_TIMEOUT)) u_wd (
        .clk  (clk),
        .rst  (rst),
        .clr  (state != S_ACCUM),
        .en   (state == S_ACCUM),
        .done (wd_done)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state decode and one-cycle register-update strobes.
    always_comb begin
        state_nxt = state;
        load_n    = 1'b0;
        cap_sum   = 1'b0;
        set_range = 1'b0;
        set_tmo   = 1'b0;
        case (state)
            S_IDLE: begin
                if (job.start) begin
                    if (job.n_in == '0 || int'(job.n_in) > P_MAX_N) begin
                        set_range = 1'b1;
                        state_nxt = S_DONE;
                    end else begin
                        load_n    = 1'b1;
                        state_nxt = S_LOAD;
                    end
                end
            end
            S_LOAD:  state_nxt = S_FETCH;
            // count==n-1 already true here only when n==1
            S_FETCH: state_nxt = dp_cmp ? S_LAST : S_ACCUM;
            S_ACCUM: begin
                if (dp_cmp) begin
                    state_nxt = S_LAST;
                end else if (wd_done) begin
                    set_tmo   = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_LAST: begin
                cap_sum   = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE:  if (job.result_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // n, result and error registers; dp_sum is only trusted in LAST.
    always_ff @(posedge clk) begin
        if (rst) begin
            dp_n       <= '0;
            job.result <= '0;
            job.err    <= ERR_OK;
        end else begin
            if (load_n)
                dp_n <= job.n_in;
            if (set_range || set_tmo) begin
                job.result <= '0;
                job.err    <= set_range ? ERR_RANGE : ERR_TIMEOUT;
            end else if (cap_sum) begin
                job.result <= dp_sum;
                job.err    <= ERR_OK;
            end
        end
    end

    assign job.ready        = (state == S_IDLE);
    assign job.result_valid = (state == S_DONE);
    assign dp_n_en          = (state == S_LOAD);
    assign dp_count_en      = (state == S_FETCH) || (state == S_ACCUM);
    assign dp_add_en        = (state == S_ACCUM) || (state == S_LAST);
    assign dp_rst           = rst || (state == S_LOAD);
    assign dp_n_rst         = rst;

endmodule
